// File: rtl/pri_enc_scan.sv
// Registered request scanner: accepts a WIDTH-bit vector, then emits the index of
// each set bit once per beat in priority order, flagging the last one.
module pri_enc_scan #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int IDXW     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out,
    output logic             out_last,
    output logic             out_zero
);

    typedef enum logic [1:0] {IDLE, SCAN, ZERO} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] pending, pending_n;
    logic [IDXW-1:0]  idx;
    logic             last;
    logic             fire;

    // Priority index of pending; scan direction lets the last hit be the winner.
    always_comb begin
        idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++)
                if (pending[i]) idx = IDXW'(i);
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--)
                if (pending[i]) idx = IDXW'(i);
        end
    end

    assign last = ((pending & (pending - WIDTH'(1))) == '0);

    always_comb begin
        in_ready  = en && (state == IDLE);
        out_valid = (state != IDLE);
        out       = (state == SCAN) ? idx : '0;
        out_last  = (state == SCAN) ? last : (state == ZERO);
        out_zero  = (state == ZERO);
    end

    assign fire = en && out_valid && out_ready;

    always_comb begin
        state_n   = state;
        pending_n = pending;
        case (state)
            IDLE: begin
                if (en && in_valid) begin
                    if (a != '0) begin
                        pending_n = a;
                        state_n   = SCAN;
                    end else begin
                        state_n   = ZERO;
                    end
                end
            end
            SCAN: begin
                if (fire) begin
                    pending_n = pending & ~(WIDTH'(1) << idx);
                    if (last) state_n = IDLE;
                end
            end
            ZERO: begin
                if (fire) state_n = IDLE;
            end
            default: begin
                state_n   = IDLE;
                pending_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
        end
    end

endmodule
